// File: rtl/alu_pkg.sv
// alu_pkg: shared types and flag helpers for the ALU result stage.
package alu_pkg;
    localparam int ALU_DATA_WIDTH = 32;
    localparam int ALU_FLAG_NEG   = 0;
    localparam int ALU_FLAG_ZERO  = 1;

    typedef struct packed {
        logic [ALU_DATA_WIDTH-1:0] high;
        logic [ALU_DATA_WIDTH-1:0] low;
        logic                      wr_hi;
        logic                      wr_lo;
        logic                      zero;
        logic                      neg;
    } alu_res_entry_t;

    localparam alu_res_entry_t ALU_RES_RESET = '{high: '0, low: '0, wr_hi: 1'b0,
                                                 wr_lo: 1'b0, zero: 1'b1, neg: 1'b0};

    // A 64-bit result is judged as a whole only when the upper half is committed.
    function automatic logic [1:0] alu_flags(input logic [ALU_DATA_WIDTH-1:0] high,
                                             input logic [ALU_DATA_WIDTH-1:0] low,
                                             input logic wr_hi);
        logic [1:0] f;
        f[ALU_FLAG_ZERO] = wr_hi ? (high == '0 && low == '0) : (low == '0);
        f[ALU_FLAG_NEG]  = wr_hi ? high[ALU_DATA_WIDTH-1] : low[ALU_DATA_WIDTH-1];
        return f;
    endfunction
endpackage

// File: rtl/alu_res_fifo2.sv
// alu_res_fifo2: 2-entry pointer/count FIFO of result entries.
// When empty, the head shows the last retired entry.
module alu_res_fifo2
    import alu_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_push,
    input  logic           i_pop,
    input  alu_res_entry_t i_data,
    output alu_res_entry_t o_head,
    output logic           o_full,
    output logic           o_empty
);
    alu_res_entry_t r_mem [2];
    alu_res_entry_t r_last;
    logic           r_wr_ptr;
    logic           r_rd_ptr;
    logic [1:0]     r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= ALU_RES_RESET;
            r_mem[1] <= ALU_RES_RESET;
            r_last   <= ALU_RES_RESET;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_head  = o_empty ? r_last : r_mem[r_rd_ptr];
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: buffered result stage with HI/LO commit on retirement and zero/neg flags.
// Optional ALU_RESULT_STALL_CNT_EN adds a saturating writeback stall counter (stall_cnt).
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int DEPTH      = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_res_high,
    input  logic [DATA_WIDTH-1:0] in_res_low,
    input  logic                  in_wr_hi,
    input  logic                  in_wr_lo,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_res_low,
    output logic [DATA_WIDTH-1:0] out_res_high,
    output logic                  out_zero,
    output logic                  out_neg,
    output logic [DATA_WIDTH-1:0] hi_q,
`ifdef ALU_RESULT_STALL_CNT_EN
    output logic [DATA_WIDTH-1:0] lo_q,
    output logic [15:0]           stall_cnt
`else
    output logic [DATA_WIDTH-1:0] lo_q
`endif
);
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [1:0]            w_flags;
    alu_res_entry_t        w_entry;
    alu_res_entry_t        w_head;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;

    // Readiness comes only from registered occupancy, never from out_ready.
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_flags   = alu_flags(in_res_high, in_res_low, in_wr_hi);
    assign w_entry   = '{high: in_res_high, low: in_res_low, wr_hi: in_wr_hi, wr_lo: in_wr_lo,
                         zero: w_flags[ALU_FLAG_ZERO], neg: w_flags[ALU_FLAG_NEG]};

    alu_res_fifo2 u_fifo (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_pop) begin
            if (w_head.wr_hi) r_hi <= w_head.high;
            if (w_head.wr_lo) r_lo <= w_head.low;
        end
    end

    assign out_res_low  = w_head.low;
    assign out_res_high = w_head.high;
    assign out_zero     = w_head.zero;
    assign out_neg      = w_head.neg;
    assign hi_q         = r_hi;
    assign lo_q         = r_lo;

`ifdef ALU_RESULT_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_stall_cnt <= '0;
        else if (out_valid && !out_ready && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end
    assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the combinational 64-bit-result op units (OR/AND/ADD/MUL-style, each producing res_high/res_low).
- Captures {res_high, res_low} with a valid/ready handshake in a 2-entry buffer and presents results to writeback.
- Commits the HI/LO architectural registers and derives zero/negative flags.
- Decouples op-unit timing from writeback backpressure.

Parameters:
- DATA_WIDTH, 32, width of each result half (res_high, res_low, HI, LO).
- DEPTH, 2, buffer entries; only 2 is supported.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  op unit presents a result.
- in_ready  out  1  stage can accept.
- in_res_high  in  DATA_WIDTH  upper result half.
- in_res_low  in  DATA_WIDTH  lower result half.
- in_wr_hi  in  1  commit res_high to HI.
- in_wr_lo  in  1  commit res_low to LO.
- out_valid  out  1  head entry available.
- out_ready  in  1  writeback accepts head.
- out_res_low  out  DATA_WIDTH  head lower half (GPR writeback value).
- out_res_high  out  DATA_WIDTH  head upper half.
- out_zero  out  1  head flag: all committed halves zero.
- out_neg  out  1  head flag: sign bit.
- hi_q  out  DATA_WIDTH  architectural HI.
- lo_q  out  DATA_WIDTH  architectural LO.

Behaviour:
- Clock and reset: one clock, clock; reset_n is asynchronous and active-low. Assertion immediately clears all state.
- Reset values:
  - count=0, rd/wr pointers=0.
  - out_valid=0, in_ready=1.
  - out_res_low/out_res_high=0, out_zero=1, out_neg=0.
  - hi_q=0, lo_q=0.
- Push: in_valid & in_ready at edge N. Entry {high, low, wr_hi, wr_lo, zero, neg} is written at wr_ptr; wr_ptr toggles.
- Pop: out_valid & out_ready at edge N. The head entry retires and rd_ptr toggles.
- Readiness:
  - in_ready = (count != 2), decoded from registered count only. No combinational path from out_ready.
  - out_valid = (count != 0).
- Latency: a push into an empty stage appears on out_* after the same edge (1-cycle latency). Throughput is 1/cycle with simultaneous push and pop.
- count transitions:
  - push only: +1.
  - pop only: -1.
  - push and pop: unchanged (legal at count=1; at count=2 push is impossible; at count=0 pop is impossible).
- Flags, computed at push from inputs:
  - If wr_hi: zero = (high==0 && low==0), neg = high[MSB].
  - Else: zero = (low==0), neg = low[MSB].
- HI/LO commit happens at pop, not push, so architectural state only changes on retirement:
  - wr_hi: hi_q <= head high.
  - wr_lo: lo_q <= head low.
  - Both flags clear: HI/LO unchanged.
- Outputs for an empty stage: out_res_* hold the last popped value. Consumers must qualify with out_valid.
- Protocol rules:
  - Once in_valid is asserted, input data is stable until accepted. Violations are not detected.
  - out_* hold stable while out_valid & !out_ready.
- Reset mid-operation: buffered entries are discarded; HI/LO return to 0; no partial commit.

Optional Feature:
- Macro: ALU_RESULT_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - Increments every cycle with out_valid & !out_ready; saturates at 16'hFFFF.
  - Cleared by reset only.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - ALU_DATA_WIDTH=32.
  - Typedef alu_res_entry_t {high, low, wr_hi, wr_lo, zero, neg}.
  - Flag-bit index constants.
- One natural sub-module: alu_res_fifo2, a 2-entry pointer/count FIFO of alu_res_entry_t.
- HI/LO commit and flag logic stay in alu_result_stage.

Test Plan:
- Reset check: assert reset_n=0 mid-stream with count=2 -> next cycle out_valid=0, in_ready=1, hi_q=lo_q=0, out_zero=1.
- Single push and commit:
  - Stimulus: push high=0, low=0xFFFF0000, wr_lo=1, out_ready=1.
  - Response: out_valid high one cycle later, out_res_low=0xFFFF0000, out_neg=1, out_zero=0; lo_q=0xFFFF0000 after pop; hi_q stays 0.
- Backpressure:
  - Stimulus: out_ready=0, push A=0x1/0x2 then B=0x3/0x4.
  - Response: in_ready=0 after second push; third push is held. Release out_ready -> A then B in order; in_ready returns to 1 after the first pop.
- Simultaneous push/pop at count=1: stream 10 results back-to-back with out_ready=1 -> count stays 1, one result per cycle, order preserved.
- 64-bit zero flag:
  - Stimulus: push high=0x00000001, low=0, wr_hi=wr_lo=1.
  - Response: out_zero=0, out_neg=0; after pop hi_q=1, lo_q=0.
- ALU_RESULT_STALL_CNT_EN defined: hold out_ready=0 with a valid head for 70000 cycles -> stall_cnt=16'hFFFF and holds.
